// File: rtl/add_controller.sv
// -----------------------------------------------------------------------------
// add_controller
//
// Moore FSM that sequences the 6-bit add datapath through
//   result = (a + b + 3*N) + (a + 3)  (mod 64)
// where N is iter_cnt sampled when start is accepted.
//
// State walk: IDLE -> LOAD -> ACC (N cycles) -> YSTEP -> OUT -> DONE -> IDLE
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   start     in   request pulse, honoured only in IDLE
//   iter_cnt  in   [CNT_W] number of ACC passes, sampled on accepted start
//   enx/eny   out  xi / yi register load enables
//   enz       out  result-capture strobe
//   sa        out  adder A select: 1 = a, 0 = xi
//   sb        out  adder B select: 1 = b, 0 = sy-selected operand
//   sc        out  adder C select, always 0
//   sy        out  when sb=0: 1 = yi, 0 = constant 3
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//
// Optional feature (macro ADD_CTRL_ABORT_EN):
//   abort     in   in LOAD/ACC/YSTEP/OUT forces the next state to DONE
//   aborted   out  set on an aborting transition, cleared by the next start
// -----------------------------------------------------------------------------
module add_controller #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [CNT_W-1:0] iter_cnt,
`ifdef ADD_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             enx,
    output logic             eny,
    output logic             enz,
    output logic             sa,
    output logic             sb,
    output logic             sc,
    output logic             sy,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ACC   = 3'd2,
        S_YSTEP = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs regardless of block order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ADD_CTRL_ABORT_EN
    logic aborted_q, aborted_d;
    logic abortable;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted   = aborted_q;
    // Only the working states can be cut short; IDLE and DONE ignore abort.
    assign abortable = (state_q == S_LOAD) || (state_q == S_ACC) ||
                       (state_q == S_YSTEP) || (state_q == S_OUT);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = iter_cnt;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q == '0) ? S_YSTEP : S_ACC;
            end
            S_ACC: begin
                // cnt enters ACC holding N, so leaving on cnt==1 gives
                // exactly N passes; N = 2^CNT_W-1 never overflows.
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_YSTEP : S_ACC;
            end
            S_YSTEP: state_d = S_OUT;
            S_OUT:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: begin
                // Unused encodings fall back to a clean IDLE.
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef ADD_CTRL_ABORT_EN
        if (abort && abortable) begin
            state_d = S_DONE;
        end
`endif
    end

`ifdef ADD_CTRL_ABORT_EN
    always_comb begin
        aborted_d = aborted_q;
        if (state_q == S_IDLE && start) begin
            aborted_d = 1'b0;
        end else if (abort && abortable) begin
            aborted_d = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Moore output decode: registered state only, no input paths
    // ------------------------------------------------------------------
    always_comb begin
        enx  = 1'b0;
        eny  = 1'b0;
        enz  = 1'b0;
        sa   = 1'b0;
        sb   = 1'b0;
        sc   = 1'b0;
        sy   = 1'b0;
        busy = 1'b0;
        done = 1'b0;

        unique case (state_q)
            S_IDLE: ;
            S_LOAD: begin          // xi <= a + b
                sa   = 1'b1;
                sb   = 1'b1;
                enx  = 1'b1;
                busy = 1'b1;
            end
            S_ACC: begin           // xi <= xi + 3
                enx  = 1'b1;
                busy = 1'b1;
            end
            S_YSTEP: begin         // yi <= a + 3
                sa   = 1'b1;
                eny  = 1'b1;
                busy = 1'b1;
            end
            S_OUT: begin           // adder shows xi + yi for capture
                sy   = 1'b1;
                enz  = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_add_controller.sv
// -----------------------------------------------------------------------------
// tb_add_controller
//
// Drives add_controller, models the 6-bit datapath from the control word the
// DUT produces, and scoreboards both the per-cycle control word sequence and
// the captured result against values derived from the formula.
// -----------------------------------------------------------------------------
module tb_add_controller;

    localparam int CNT_W = 4;

    // Control word order: {enx, eny, enz, sa, sb, sc, sy, busy, done}
    localparam logic [8:0] W_IDLE  = 9'b000000000;
    localparam logic [8:0] W_LOAD  = 9'b100110010;
    localparam logic [8:0] W_ACC   = 9'b100000010;
    localparam logic [8:0] W_YSTEP = 9'b010100010;
    localparam logic [8:0] W_OUT   = 9'b001000110;
    localparam logic [8:0] W_DONE  = 9'b000000011;

    logic             CLK   = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] iter_cnt = '0;
    logic             enx, eny, enz, sa, sb, sc, sy, busy, done;
`ifdef ADD_CTRL_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    always #5 CLK = ~CLK;

    add_controller #(.CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .iter_cnt (iter_cnt),
`ifdef ADD_CTRL_ABORT_EN
        .abort    (abort),
        .aborted  (aborted),
`endif
        .enx      (enx),
        .eny      (eny),
        .enz      (enz),
        .sa       (sa),
        .sb       (sb),
        .sc       (sc),
        .sy       (sy),
        .busy     (busy),
        .done     (done)
    );

    // Datapath model driven by the DUT's control word
    logic [5:0] a_in = '0;
    logic [5:0] b_in = '0;
    logic [5:0] xi_m = '0;
    logic [5:0] yi_m = '0;
    logic [5:0] op_a, op_b, sum;

    assign op_a = sa ? a_in : xi_m;
    assign op_b = sb ? b_in : (sy ? yi_m : 6'd3);
    assign sum  = op_a + op_b;

    always @(posedge CLK) begin
        if (enx) xi_m <= sum;
        if (eny) yi_m <= sum;
    end

    wire [8:0] ctrl = {enx, eny, enz, sa, sb, sc, sy, busy, done};

    // Scoreboards
    logic [8:0] exp_q[$];
    logic [5:0] res_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Compare the current control word with the next expected one (IDLE when
    // nothing is scheduled), and the captured result on the enz cycle.
    task automatic sample();
        logic [8:0] want;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : W_IDLE;
        check("ctrl", 16'(ctrl), 16'(want));
        check("enable_exclusive",
              16'(($countones({enx, eny, enz}) <= 1) && !(done && (enx || eny || enz))), 16'd1);
        if (enz) begin
            if (res_q.size() > 0) check("result", 16'(sum), 16'(res_q.pop_front()));
            else                  check("unexpected_enz", 16'(enz), 16'd0);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        sample();
    endtask

    task automatic push_run(input int n, input int a, input int b);
        exp_q.push_back(W_LOAD);
        repeat (n) exp_q.push_back(W_ACC);
        exp_q.push_back(W_YSTEP);
        exp_q.push_back(W_OUT);
        exp_q.push_back(W_DONE);
        res_q.push_back(6'((a + b + 3 * n + a + 3) % 64));
    endtask

    // Full run: accept at edge k, then N+3 busy samples, then one IDLE sample.
    task automatic launch(input int n, input int a, input int b);
        iter_cnt = CNT_W'(n);
        a_in     = 6'(a);
        b_in     = 6'(b);
        start    = 1'b1;
        push_run(n, a, b);
        tick();
        start    = 1'b0;
        iter_cnt = ~CNT_W'(n);   // changes while busy must not matter
        repeat (n + 3) tick();
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_ctrl", 16'(ctrl), 16'(W_IDLE));
`ifdef ADD_CTRL_ABORT_EN
        check("reset_aborted", 16'(aborted), 16'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // N=0, a=5, b=7 -> 20
        launch(0, 5, 7);
        // N=2, a=5, b=7 -> 26
        launch(2, 5, 7);
        // N=15, a=b=63 -> 45 with wrap
        launch(15, 63, 63);

        // Reset mid-ACC with N=5
        iter_cnt = 4'd5;
        a_in     = 6'd9;
        b_in     = 6'd4;
        start    = 1'b1;
        push_run(5, 9, 4);
        tick();                 // LOAD
        start = 1'b0;
        tick();                 // ACC
        tick();                 // ACC
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_ctrl", 16'(ctrl), 16'(W_IDLE));
        exp_q.delete();
        res_q.delete();
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("rst_hold_ctrl", 16'(ctrl), 16'(W_IDLE));
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("rst_release_busy", 16'(busy), 16'd0);

        // Handshake: start during ACC and during DONE is ignored
        iter_cnt = 4'd3;
        a_in     = 6'd10;
        b_in     = 6'd20;
        start    = 1'b1;
        push_run(3, 10, 20);
        tick();                 // LOAD
        start = 1'b0;
        tick();                 // ACC1
        start = 1'b1;
        tick();                 // ACC2, start ignored
        start = 1'b0;
        repeat (4) tick();      // ACC3, YSTEP, OUT, DONE
        start = 1'b1;
        tick();                 // start seen in DONE: must stay IDLE
        start = 1'b0;
        tick();

        // start held high: back-to-back runs with one IDLE cycle between
        iter_cnt = 4'd1;
        a_in     = 6'd1;
        b_in     = 6'd2;
        start    = 1'b1;
        push_run(1, 1, 2);
        exp_q.push_back(W_IDLE);
        push_run(1, 1, 2);
        repeat (7) tick();      // run 1 (5), IDLE, LOAD of run 2
        start = 1'b0;
        repeat (5) tick();      // ACC, YSTEP, OUT, DONE, IDLE

`ifdef ADD_CTRL_ABORT_EN
        // Abort during the second ACC cycle of N=4
        iter_cnt = 4'd4;
        a_in     = 6'd3;
        b_in     = 6'd3;
        start    = 1'b1;
        exp_q.push_back(W_LOAD);
        exp_q.push_back(W_ACC);
        exp_q.push_back(W_ACC);
        exp_q.push_back(W_DONE);
        tick();                 // LOAD
        start = 1'b0;
        check("aborted_pre", 16'(aborted), 16'd0);
        tick();                 // ACC1
        tick();                 // ACC2
        abort = 1'b1;
        tick();                 // DONE
        abort = 1'b0;
        check("aborted_set", 16'(aborted), 16'd1);
        tick();                 // IDLE
        check("aborted_hold", 16'(aborted), 16'd1);
        abort = 1'b1;
        tick();                 // abort in IDLE has no effect
        abort = 1'b0;
        // Next start clears aborted
        iter_cnt = 4'd0;
        a_in     = 6'd5;
        b_in     = 6'd7;
        start    = 1'b1;
        push_run(0, 5, 7);
        tick();                 // LOAD
        start = 1'b0;
        check("aborted_clr", 16'(aborted), 16'd0);
        repeat (3) tick();
        tick();
`endif

        check("scoreboard_drained", 16'(exp_q.size() + res_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/add_controller.md
Name: add_controller

Overview:
- Moore FSM that sequences the 6-bit add datapath through a multi-step computation.
- Drives the datapath control word: enx, eny, enz, sa, sb, sc, sy.
- Gives the host a start/busy/done handshake.
- Resulting datapath computation: result = (a + b + 3*N) + (a + 3), modulo 64, where N is the iteration count sampled at start.

Parameters:
- CNT_W, 4, width of the iteration counter and of iter_cnt.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST_N  input  1  asynchronous active-low reset
- start  input  1  request pulse; honoured only in IDLE
- iter_cnt  input  CNT_W  number of ACC passes N; sampled on accepted start
- enx  output  1  xi register load enable
- eny  output  1  yi register load enable
- enz  output  1  result-capture strobe
- sa  output  1  adder A select: 1 = a, 0 = xi
- sb  output  1  adder B select: 1 = b, 0 = see sy
- sc  output  1  adder C select; tied 0 in this revision
- sy  output  1  when sb=0: 1 = yi, 0 = constant 3
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock, reset: one clock (CLK). Reset is asynchronous and active-low (RST_N). On reset the state is IDLE, the counter is 0 and every output is 0.
- Output decode: all outputs decode combinationally from the registered state only (Moore). No input-to-output combinational path.
- States and control words. Unlisted outputs are 0; sc is always 0.
  - IDLE: all controls 0; busy=0. If start=1, latch iter_cnt into cnt and go to LOAD.
  - LOAD: sa=1, sb=1, enx=1, giving xi <= a+b. If cnt==0 go to YSTEP, else go to ACC.
  - ACC: sa=0, sb=0, sy=0, enx=1, giving xi <= xi+3. cnt decrements each cycle. Go to YSTEP when cnt==1 at the edge, else stay in ACC. Occupies exactly N cycles.
  - YSTEP: sa=1, sb=0, sy=0, eny=1, giving yi <= a+3.
  - OUT: sa=0, sb=0, sy=1, enz=1; the adder presents xi+yi for capture.
  - DONE: done=1, all controls 0, busy=1. Unconditionally go to IDLE.
- Latency: if start is accepted at edge k, LOAD is entered at k, OUT at k+N+2, DONE at k+N+3 and IDLE at k+N+4. Total busy span is N+4 cycles.
- Handshake:
  - start while busy=1, including the DONE cycle, is ignored and not queued.
  - start held high continuously re-launches from the first IDLE cycle after DONE.
  - iter_cnt changes while busy have no effect.
- Width rules: cnt is CNT_W bits. N = 2^CNT_W-1 is supported with no overflow. All datapath sums wrap modulo 64; the controller is unaware of the wrap.
- Invariants:
  - At most one of enx/eny/enz is high in any cycle.
  - done is never high in the same cycle as any enable.
- Reset mid-operation: the FSM returns to IDLE immediately, asynchronously. Outputs go to 0 with no done pulse. Partial xi/yi contents are don't-care.
- Illegal or unused state encodings recover to IDLE on the next edge with outputs 0.

Optional Feature:
- Macro: ADD_CTRL_ABORT_EN
- Defined:
  - Adds an input port abort (1 bit).
  - abort=1 in LOAD, ACC, YSTEP or OUT forces the next state to DONE, which still pulses done.
  - Adds an output aborted (1 bit). It is set on that transition and cleared when the next start is accepted. Reset value 0.
  - abort has no effect in IDLE or DONE.
- Undefined: no abort or aborted ports exist; the sequence always completes.

Test Plan:
- Reset: RST_N low mid-ACC with N=5 -> all outputs 0 within the same cycle, no done pulse; after release, state is IDLE and busy=0.
- N=0: start with iter_cnt=0, a=5, b=7 -> control words LOAD, YSTEP, OUT, DONE on consecutive cycles; done at k+3; model result=20.
- N=2: start with a=5, b=7 -> 2 ACC cycles, xi=18, yi=8, result=26 captured on the enz cycle; done at k+5.
- Wrap: N=15 (max), a=b=63 -> xi=(126+45) mod 64=43, yi=2, result=45; no counter overflow; done at k+18.
- Handshake: pulse start during ACC and again during DONE -> both ignored; hold start high -> back-to-back runs with exactly one IDLE cycle between them; one-hot enable check passes every cycle.
- ADD_CTRL_ABORT_EN: abort during the second ACC cycle of N=4 -> next state DONE, done pulses, aborted=1; the next start clears aborted.
